donut_fb_ctrl: RTL and testbench

Frame-buffer controller for the donut renderer. Owns the 32K x 4-bit `donut_ram` and sequences each frame: a hardware clear pass, then a draw phase that accepts renderer pixel writes over a valid/ready handshake. It serves display scan reads continuously on the RAM read port, with fixed 1-cycle latency. It sits between the donut renderer (write side) and the video scan-out logic (read side).

---
 rtl/donut_pkg.sv | 18 +
 rtl/donut_ram.sv | 31 +++
 rtl/donut_fb_ctrl.sv | 147 ++++++++++++++
 tb/tb_donut_fb_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/donut_pkg.sv
// donut_pkg: shared sizes and FSM state type for the donut frame-buffer slice.
//   ADDR_W   - pixel address width (32K pixels)
//   PIX_W    - pixel value width
//   FB_DEPTH - number of frame-buffer locations
package donut_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned PIX_W    = 4;
  localparam int unsigned FB_DEPTH = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } fb_state_t;

endpackage

// File: rtl/donut_ram.sv
// donut_ram: 32K x 4 single-clock RAM with one write port and one read port.
// There is no write enable: every enabled cycle writes wr_data_i to wr_addr_i.
// Reads are read-first with a registered output (1-cycle latency).
//   clk_i     - clock
//   cen_i     - chip enable, gates both ports
//   wr_addr_i - write address
//   wr_data_i - write data
//   rd_addr_i - read address
//   rd_data_o - registered read data
module donut_ram
  import donut_pkg::*;
(
  input  logic              clk_i,
  input  logic              cen_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [FB_DEPTH];

  // Both ports in one block: the read samples the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (cen_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
      rd_data_o        <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/donut_fb_ctrl.sv
// donut_fb_ctrl: frame-buffer controller. Runs a hardware clear pass, then
// accepts renderer pixel writes, while serving display reads every cycle.
//   clk_i, rst_i          - clock, synchronous active-high reset
//   frame_start_i         - pulse: start a frame (clear, then draw)
//   draw_done_i           - pulse: renderer finished drawing
//   wr_valid_i/wr_ready_o - renderer write handshake
//   wr_addr_i, wr_data_i  - renderer pixel write
//   rd_en_i, rd_addr_i    - display read request
//   rd_data_o, rd_valid_o - display read result, 1 cycle later
//   clearing_o/drawing_o  - FSM is in CLEAR / DRAW
//   frame_done_o          - 1-cycle pulse when a frame completes
//   overrun_o             - sticky: frame restarted during draw
//   addr_err_o            - sticky: renderer wrote the sink address
module donut_fb_ctrl
  import donut_pkg::*;
#(
  parameter logic [PIX_W-1:0]  CLEAR_VAL = 4'h0,
  parameter logic [ADDR_W-1:0] SINK_ADDR = 15'h7FFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic              draw_done_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              clearing_o,
  output logic              drawing_o,
  output logic              frame_done_o,
  output logic              overrun_o,
  output logic              addr_err_o
);

  localparam logic [ADDR_W-1:0] CLR_LAST = SINK_ADDR - ADDR_W'(1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              overrun_q, overrun_d;
  logic              addr_err_q, addr_err_d;
  logic              frame_done_q;
  logic              rd_valid_q;
  logic              rd_sink_q;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [PIX_W-1:0]  ram_wr_data;
  logic [PIX_W-1:0]  ram_rd_data;

  // Next state, clear counter, sticky flags and RAM write-port mux.
  // With no write enable, idle cycles park the write on the sink address.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    overrun_d   = overrun_q;
    addr_err_d  = addr_err_q;
    ram_wr_addr = SINK_ADDR;
    ram_wr_data = CLEAR_VAL;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        ram_wr_addr = clr_cnt_q;
        if (frame_start_i) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d   = DRAW;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      DRAW: begin
        if (wr_valid_i) begin
          if (wr_addr_i == SINK_ADDR) begin
            addr_err_d = 1'b1;
          end else begin
            ram_wr_addr = wr_addr_i;
            ram_wr_data = wr_data_i;
          end
        end
        // A restart beats draw completion.
        if (frame_start_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          overrun_d = 1'b1;
        end else if (draw_done_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, flags and read-pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_sink_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      overrun_q    <= overrun_d;
      addr_err_q   <= addr_err_d;
      frame_done_q <= (state_d == DONE);
      rd_valid_q   <= rd_en_i;
      rd_sink_q    <= (rd_addr_i == SINK_ADDR);
    end
  end

  donut_ram u_ram (
    .clk_i     (clk_i),
    .cen_i     (1'b1),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (ram_wr_data),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (ram_rd_data)
  );

  assign wr_ready_o   = (state_q == DRAW);
  assign clearing_o   = (state_q == CLEAR);
  assign drawing_o    = (state_q == DRAW);
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;
  assign addr_err_o   = addr_err_q;
  assign rd_valid_o   = rd_valid_q;

  // The sink holds dummy-write garbage, so it always reads as the clear value.
  assign rd_data_o = !rd_valid_q ? '0 : (rd_sink_q ? CLEAR_VAL : ram_rd_data);

endmodule

// File: tb/tb_donut_fb_ctrl.sv
// tb_donut_fb_ctrl: randomized bench for donut_fb_ctrl with a behavioural
// frame-buffer model and a per-cycle output comparison, plus literal checks.
module tb_donut_fb_ctrl;

  localparam int SINK       = 'h7FFF;
  localparam int CLR_CYCLES = 32767;
  localparam int DEPTH      = 32768;

  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_DRAW  = 2;
  localparam int PH_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst, fs, dd, wr_valid, rd_en;
  logic [14:0] wr_addr, rd_addr;
  logic [3:0]  wr_data;
  logic        wr_ready_o, rd_valid_o, clearing_o, drawing_o;
  logic        frame_done_o, overrun_o, addr_err_o;
  logic [3:0]  rd_data_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  donut_fb_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_start_i (fs),
    .draw_done_i   (dd),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready_o),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .clearing_o    (clearing_o),
    .drawing_o     (drawing_o),
    .frame_done_o  (frame_done_o),
    .overrun_o     (overrun_o),
    .addr_err_o    (addr_err_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mem_m holds -1 for locations whose content is not known yet.
  int  ph, clr_next;
  int  mem_m [DEPTH];
  int  e_rd_valid, e_rd_data, e_done, e_overrun, e_err;
  bit  live = 1'b0;

  initial foreach (mem_m[i]) mem_m[i] = -1;

  always @(posedge clk) begin
    if (rst) begin
      ph = PH_IDLE; clr_next = 0;
      e_rd_valid = 0; e_rd_data = 0; e_done = 0; e_overrun = 0; e_err = 0;
      live = 1'b1;
    end else begin
      // read sees the memory as it was before this cycle's write
      e_rd_valid = rd_en ? 1 : 0;
      e_rd_data  = !rd_en ? 0 : (int'(rd_addr) == SINK ? 0 : mem_m[rd_addr]);
      e_done = 0;
      case (ph)
        PH_IDLE: if (fs) begin ph = PH_CLEAR; clr_next = 0; end
        PH_CLEAR: begin
          mem_m[clr_next] = 0;
          if (fs) clr_next = 0;
          else if (clr_next == CLR_CYCLES - 1) ph = PH_DRAW;
          else clr_next++;
        end
        PH_DRAW: begin
          if (wr_valid) begin
            if (int'(wr_addr) == SINK) e_err = 1;
            else mem_m[wr_addr] = int'(wr_data);
          end
          if (fs) begin ph = PH_CLEAR; clr_next = 0; e_overrun = 1; end
          else if (dd) begin ph = PH_DONE; e_done = 1; end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("wr_ready",   int'(wr_ready_o),   int'(ph == PH_DRAW));
      chk("clearing",   int'(clearing_o),   int'(ph == PH_CLEAR));
      chk("drawing",    int'(drawing_o),    int'(ph == PH_DRAW));
      chk("frame_done", int'(frame_done_o), e_done);
      chk("overrun",    int'(overrun_o),    e_overrun);
      chk("addr_err",   int'(addr_err_o),   e_err);
      chk("rd_valid",   int'(rd_valid_o),   e_rd_valid);
      if (e_rd_data >= 0) chk("rd_data", int'(rd_data_o), e_rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    fs = 1'b0; dd = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [14:0] pick_wr();
    if ($urandom % 16 == 0) return 15'h7FFF;
    return 15'h400 + 15'($urandom % 64);
  endfunction

  function automatic logic [14:0] pick_rd();
    int r = int'($urandom % 16);
    if (r == 0) return 15'h7FFF;
    if (r < 4)  return 15'($urandom);
    return 15'h400 + 15'($urandom % 64);
  endfunction

  task automatic rand_io();
    rd_en    = 1'($urandom % 2);
    rd_addr  = pick_rd();
    wr_valid = 1'($urandom % 2);
    wr_addr  = pick_wr();
    wr_data  = 4'($urandom % 16);
  endtask

  task automatic write1(input logic [14:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic read_chk(input string name, input logic [14:0] a, input int exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    chk({name, "_valid"}, int'(rd_valid_o), 1);
    chk(name, int'(rd_data_o), exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    rst = 1'b1; fs = 1'b0; dd = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) step();
    chk("rst_wr_ready",   int'(wr_ready_o), 0);
    chk("rst_rd_valid",   int'(rd_valid_o), 0);
    chk("rst_clearing",   int'(clearing_o), 0);
    chk("rst_drawing",    int'(drawing_o), 0);
    chk("rst_frame_done", int'(frame_done_o), 0);
    chk("rst_overrun",    int'(overrun_o), 0);
    chk("rst_addr_err",   int'(addr_err_o), 0);
    chk("rst_rd_data",    int'(rd_data_o), 0);
    rst = 1'b0;
    step();

    // frame 1: full clear with ignored write attempts and random reads
    fs = 1'b1;
    step();
    cnt = 0;
    while (clearing_o && cnt < 40000) begin
      cnt++;
      rand_io();
      step();
    end
    chk("clear1_len", cnt, CLR_CYCLES);
    chk("clear1_to_draw", int'(drawing_o), 1);
    read_chk("rd_0",    15'h0000, 0);
    read_chk("rd_1234", 15'h1234, 0);
    read_chk("rd_7ffe", 15'h7FFE, 0);

    write1(15'h05A0, 4'h9);
    chk("no_rd_valid_idle", int'(rd_valid_o), 0);
    read_chk("rd_5a0_new", 15'h05A0, 9);
    wr_valid = 1'b1; wr_addr = 15'h05A0; wr_data = 4'h3;
    read_chk("rd_5a0_readfirst", 15'h05A0, 9);
    read_chk("rd_5a0_after", 15'h05A0, 3);
    read_chk("rd_sink_a", 15'h7FFF, 0);
    chk("wr_ready_draw", int'(wr_ready_o), 1);
    write1(15'h7FFF, 4'hF);
    chk("addr_err_set", int'(addr_err_o), 1);
    read_chk("rd_sink_b", 15'h7FFF, 0);
    write1(15'h0100, 4'h7);
    read_chk("rd_100_pre", 15'h0100, 7);
    write1(15'h6000, 4'h2);
    write1(15'h0010, 4'hC);

    repeat (1500) begin
      rand_io();
      step();
    end
    chk("addr_err_sticky", int'(addr_err_o), 1);

    // handshake together with draw_done
    wr_valid = 1'b1; wr_addr = 15'h0222; wr_data = 4'h5; dd = 1'b1;
    step();
    chk("done_pulse", int'(frame_done_o), 1);
    chk("done_not_draw", int'(drawing_o), 0);
    step();
    chk("done_one_cycle", int'(frame_done_o), 0);
    chk("idle_wr_ready", int'(wr_ready_o), 0);
    read_chk("rd_222", 15'h0222, 5);
    dd = 1'b1;
    step();
    step();
    chk("idle_dd_ignored", int'(frame_done_o), 0);

    // frame 2: write attempt during clear, restart in clear, reset mid-clear
    fs = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      rd_en = 1'($urandom % 2); rd_addr = pick_rd();
      if (i == 100) begin wr_valid = 1'b1; wr_addr = 15'h6000; wr_data = 4'h7; end
      step();
    end
    read_chk("rd_6000_clear_wr_blocked", 15'h6000, 2);
    fs = 1'b1;
    step();
    repeat (1000) begin
      rd_en = 1'($urandom % 2); rd_addr = pick_rd();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_clearing", int'(clearing_o), 0);
    chk("rst2_drawing",  int'(drawing_o), 0);
    chk("rst2_addr_err", int'(addr_err_o), 0);
    read_chk("rd_6000_kept", 15'h6000, 2);
    read_chk("rd_5a0_kept",  15'h05A0, 3);

    // frame 3: full clear after reset, write attempts at 0x100
    fs = 1'b1;
    step();
    cnt = 0;
    while (clearing_o && cnt < 40000) begin
      cnt++;
      rand_io();
      if (cnt % 97 == 0) begin wr_valid = 1'b1; wr_addr = 15'h0100; wr_data = 4'h7; end
      step();
    end
    chk("clear3_len", cnt, CLR_CYCLES);
    read_chk("rd_100_cleared",  15'h0100, 0);
    read_chk("rd_7ffe_cleared", 15'h7FFE, 0);
    read_chk("rd_6000_cleared", 15'h6000, 0);
    read_chk("rd_5a0_cleared",  15'h05A0, 0);
    write1(15'h0010, 4'hC);
    repeat (800) begin
      rand_io();
      step();
    end

    // frame_start and draw_done together: restart wins
    fs = 1'b1; dd = 1'b1;
    step();
    chk("ovr_no_done", int'(frame_done_o), 0);
    chk("ovr_flag", int'(overrun_o), 1);
    chk("ovr_clearing", int'(clearing_o), 1);
    read_chk("rd_10_not_yet", 15'h0010, 12);
    repeat (30) step();
    read_chk("rd_10_cleared", 15'h0010, 0);
    chk("ovr_sticky", int'(overrun_o), 1);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
